// File: rtl/ram_controlador.sv
// ram_controlador
//   Request/response front end for a small word-organised RAM built from
//   individually enabled words. After reset the controller zero-fills every
//   word (INIT), then serves one request at a time: accept (IDLE), drive the
//   memory for one cycle (ACCESS), present the response until taken (RESP).
//   Every output is a register, so nothing on req_* or resp_ready reaches
//   mem_* or any other output combinationally.
//
// Ports
//   clock            system clock, rising edge
//   clear            asynchronous active-low reset
//   req_valid        request present
//   req_ready        controller accepts a request this cycle
//   req_rw           1 = write, 0 = read
//   req_endereco     target word address
//   req_data         write data
//   resp_valid       response present
//   resp_ready       consumer accepts the response
//   resp_data        read data (0 for write responses)
//   resp_escrita     response belongs to a write
//   init_done        power-up zero sweep finished (sticky until reset)
//   mem_rw           memory write enable shared by all words
//   mem_endereco     one-hot word select
//   mem_data_entrada memory write data
//   mem_data_saida   OR of all word outputs (0 for deselected words)
module ram_controlador #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 2
) (
  input  logic                   clock,
  input  logic                   clear,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_rw,
  input  logic [ADDR_W-1:0]      req_endereco,
  input  logic [DATA_W-1:0]      req_data,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [DATA_W-1:0]      resp_data,
  output logic                   resp_escrita,
  output logic                   init_done,
  output logic                   mem_rw,
  output logic [2**ADDR_W-1:0]   mem_endereco,
  output logic [DATA_W-1:0]      mem_data_entrada,
  input  logic [DATA_W-1:0]      mem_data_saida
);

  localparam int N = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N - 1);

  typedef enum logic [1:0] {
    INIT   = 2'd0,
    IDLE   = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t              state, state_next;
  logic [ADDR_W-1:0]   cnt, cnt_next;
  // Set once the first sweep word has been issued; lets the first edge after
  // reset release start the sweep while outputs still read 0 during reset.
  logic                sweep_on, sweep_on_next;
  logic                rw_q, rw_next;

  logic                req_ready_next;
  logic                resp_valid_next;
  logic [DATA_W-1:0]   resp_data_next;
  logic                resp_escrita_next;
  logic                init_done_next;
  logic                mem_rw_next;
  logic [N-1:0]        mem_endereco_next;
  logic [DATA_W-1:0]   mem_data_entrada_next;

  function automatic logic [N-1:0] one_hot(input logic [ADDR_W-1:0] a);
    logic [N-1:0] v;
    v    = '0;
    v[a] = 1'b1;
    return v;
  endfunction

  // Next-state and next-output decode. Outputs are computed for the state
  // being entered and registered at the edge, so each state's outputs are
  // valid for exactly the cycles the controller spends in it.
  always_comb begin
    state_next            = state;
    cnt_next              = cnt;
    sweep_on_next         = sweep_on;
    rw_next               = rw_q;
    req_ready_next        = 1'b0;
    resp_valid_next       = resp_valid;
    resp_data_next        = resp_data;
    resp_escrita_next     = resp_escrita;
    init_done_next        = init_done;
    mem_rw_next           = 1'b0;
    mem_endereco_next     = '0;
    mem_data_entrada_next = '0;

    case (state)
      INIT: begin
        if (!sweep_on) begin
          sweep_on_next     = 1'b1;
          mem_rw_next       = 1'b1;
          mem_endereco_next = one_hot(cnt);
        end else if (cnt == LAST) begin
          state_next     = IDLE;
          init_done_next = 1'b1;
          req_ready_next = 1'b1;
        end else begin
          cnt_next          = cnt + ADDR_W'(1);
          mem_rw_next       = 1'b1;
          mem_endereco_next = one_hot(cnt_next);
        end
      end

      IDLE: begin
        req_ready_next = 1'b1;
        if (req_valid && req_ready) begin
          state_next            = ACCESS;
          req_ready_next        = 1'b0;
          rw_next               = req_rw;
          mem_rw_next           = req_rw;
          mem_endereco_next     = one_hot(req_endereco);
          mem_data_entrada_next = req_rw ? req_data : '0;
        end
      end

      ACCESS: begin
        state_next      = RESP;
        resp_valid_next = 1'b1;
        if (rw_q) begin
          resp_data_next    = '0;
          resp_escrita_next = 1'b1;
        end else begin
          resp_data_next    = mem_data_saida;
          resp_escrita_next = 1'b0;
        end
      end

      RESP: begin
        if (resp_ready) begin
          state_next      = IDLE;
          resp_valid_next = 1'b0;
          req_ready_next  = 1'b1;
        end
      end

      default: state_next = INIT;
    endcase
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state            <= INIT;
      cnt              <= '0;
      sweep_on         <= 1'b0;
      rw_q             <= 1'b0;
      req_ready        <= 1'b0;
      resp_valid       <= 1'b0;
      resp_data        <= '0;
      resp_escrita     <= 1'b0;
      init_done        <= 1'b0;
      mem_rw           <= 1'b0;
      mem_endereco     <= '0;
      mem_data_entrada <= '0;
    end else begin
      state            <= state_next;
      cnt              <= cnt_next;
      sweep_on         <= sweep_on_next;
      rw_q             <= rw_next;
      req_ready        <= req_ready_next;
      resp_valid       <= resp_valid_next;
      resp_data        <= resp_data_next;
      resp_escrita     <= resp_escrita_next;
      init_done        <= init_done_next;
      mem_rw           <= mem_rw_next;
      mem_endereco     <= mem_endereco_next;
      mem_data_entrada <= mem_data_entrada_next;
    end
  end

endmodule

// File: tb/tb_ram_controlador.sv
// tb_ram_controlador
//   Bench for ram_controlador (DATA_W=4, ADDR_W=2). A small word-enable RAM
//   model hangs off the mem_* port. Expected responses are queued when a
//   request is issued; a monitor pops and compares on each response handshake.
module tb_ram_controlador;

  logic       clock = 1'b0;
  logic       clear = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_rw = 1'b0;
  logic [1:0] req_endereco = 2'd0;
  logic [3:0] req_data = 4'd0;
  logic       resp_valid;
  logic       resp_ready = 1'b1;
  logic [3:0] resp_data;
  logic       resp_escrita;
  logic       init_done;
  logic       mem_rw;
  logic [3:0] mem_endereco;
  logic [3:0] mem_data_entrada;
  logic [3:0] mem_data_saida;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int last_acc = -100;
  logic prev_rv = 1'b0;

  logic [4:0] exp_q[$];   // {resp_escrita, resp_data}

  // Memory words start at non-zero garbage so the INIT sweep is observable.
  logic [3:0] mem [4] = '{4'hF, 4'hF, 4'hF, 4'hF};

  ram_controlador #(.DATA_W(4), .ADDR_W(2)) dut (
    .clock(clock),
    .clear(clear),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_rw(req_rw),
    .req_endereco(req_endereco),
    .req_data(req_data),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_data(resp_data),
    .resp_escrita(resp_escrita),
    .init_done(init_done),
    .mem_rw(mem_rw),
    .mem_endereco(mem_endereco),
    .mem_data_entrada(mem_data_entrada),
    .mem_data_saida(mem_data_saida)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    cyc <= cyc + 1;
    for (int i = 0; i < 4; i++)
      if (mem_rw && mem_endereco[i]) mem[i] <= mem_data_entrada;
  end

  always_comb begin
    mem_data_saida = 4'd0;
    for (int i = 0; i < 4; i++)
      if (mem_endereco[i]) mem_data_saida = mem_data_saida | mem[i];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Response scoreboard: pop on every handshake.
  always @(negedge clock) begin
    if (clear && resp_valid && resp_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL resp_unexpected actual=%0h required=none", {resp_escrita, resp_data});
      end else begin
        check("resp", 32'({resp_escrita, resp_data}), 32'(exp_q.pop_front()));
      end
    end
  end

  // Acceptance monitor: init_done at accept, spacing between accepts, and
  // response latency of one cycle after the acceptance edge.
  always @(negedge clock) begin
    if (clear && req_valid && req_ready) begin
      check("accept_init_done", 32'(init_done), 32'd1);
      checks++;
      if (cyc + 1 - last_acc < 3) begin
        errors++;
        $display("FAIL accept_spacing actual=%0d required>=3", cyc + 1 - last_acc);
      end
      last_acc = cyc + 1;
      acc_cyc  = cyc + 1;
    end
    if (clear && resp_valid && !prev_rv)
      check("resp_latency", 32'(cyc - acc_cyc), 32'd1);
    prev_rv = resp_valid;
  end

  task automatic check_sweep();
    logic [3:0] oh;
    for (int i = 0; i < 4; i++) begin
      @(posedge clock); #1;
      oh = 4'b0001 << i;
      check("sweep_word", 32'({mem_rw, mem_endereco, mem_data_entrada, req_ready, init_done}),
            32'({1'b1, oh, 4'b0000, 1'b0, 1'b0}));
    end
    @(posedge clock); #1;
    check("sweep_done", 32'({init_done, req_ready, mem_rw, mem_endereco}), 32'({1'b1, 1'b1, 1'b0, 4'b0000}));
  endtask

  // Returns #1 after the acceptance edge, with req_valid dropped.
  task automatic wait_accept();
    int n = 0;
    @(negedge clock);
    while (!req_ready && n < 30) begin
      @(negedge clock);
      n++;
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout actual=%0d required=1", req_ready);
    end
    @(posedge clock); #1;
    req_valid = 1'b0;
  endtask

  task automatic issue(input logic rw, input logic [1:0] a, input logic [3:0] d,
                       input logic push, input logic [3:0] exp);
    if (push) exp_q.push_back({rw, exp});
    req_rw       = rw;
    req_endereco = a;
    req_data     = d;
    req_valid    = 1'b1;
    wait_accept();
  endtask

  task automatic wait_resp();
    int n = 0;
    @(negedge clock);
    while (!(resp_valid && resp_ready) && n < 30) begin
      @(negedge clock);
      n++;
    end
    if (!(resp_valid && resp_ready)) begin
      checks++;
      errors++;
      $display("FAIL resp_timeout actual=%0d required=1", resp_valid);
    end
    @(posedge clock); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int n;
    int got;
    // Reset with a read of address 3 already pending; it must wait for INIT.
    #3 clear = 1'b0;
    exp_q.push_back({1'b0, 4'b0000});
    req_rw = 1'b0; req_endereco = 2'd3; req_valid = 1'b1;
    repeat (2) @(negedge clock);
    check("reset_state", 32'({req_ready, resp_valid, resp_data, resp_escrita, init_done,
                              mem_rw, mem_endereco, mem_data_entrada}), 32'd0);
    @(negedge clock) clear = 1'b1;
    check_sweep();
    wait_accept();
    check("access_rd3", 32'({mem_rw, mem_endereco, req_ready}), 32'({1'b0, 4'b1000, 1'b0}));
    wait_resp();

    // Write 1010 to address 2, then read it back.
    issue(1'b1, 2'd2, 4'b1010, 1'b1, 4'b0000);
    check("access_wr2", 32'({mem_rw, mem_endereco, mem_data_entrada}), 32'({1'b1, 4'b0100, 4'b1010}));
    wait_resp();
    issue(1'b0, 2'd2, 4'b0000, 1'b1, 4'b1010);
    wait_resp();

    // Back-to-back reads with req_valid held high.
    for (int k = 0; k < 3; k++) exp_q.push_back({1'b0, 4'b1010});
    req_rw = 1'b0; req_endereco = 2'd2; req_valid = 1'b1;
    got = 0; n = 0;
    while (got < 3 && n < 40) begin
      @(negedge clock);
      n++;
      if (req_valid && req_ready) got++;
    end
    check("burst_accepts", 32'(got), 32'd3);
    @(posedge clock); #1;
    req_valid = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge clock);
      n++;
    end
    check("burst_drained", 32'(exp_q.size()), 32'd0);
    @(posedge clock); #1;

    // Response stall: resp_ready low for 5 cycles in RESP.
    resp_ready = 1'b0;
    issue(1'b0, 2'd2, 4'b0000, 1'b1, 4'b1010);
    @(posedge clock); #1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      check("stall_hold", 32'({resp_valid, resp_data, resp_escrita, req_ready, mem_rw,
                               mem_endereco, mem_data_entrada}),
            32'({1'b1, 4'b1010, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000}));
    end
    @(posedge clock); #1;
    resp_ready = 1'b1;
    wait_resp();
    check("stall_release", 32'({resp_valid, req_ready}), 32'({1'b0, 1'b1}));

    // Reset during ACCESS of a write of 1111 to address 1.
    issue(1'b1, 2'd1, 4'b0101, 1'b1, 4'b0000);
    wait_resp();
    issue(1'b1, 2'd1, 4'b1111, 1'b0, 4'b0000);
    check("abort_access", 32'({mem_rw, mem_endereco, mem_data_entrada}), 32'({1'b1, 4'b0010, 4'b1111}));
    #2 clear = 1'b0;
    #1;
    check("abort_zero", 32'({req_ready, resp_valid, resp_data, resp_escrita, init_done,
                             mem_rw, mem_endereco, mem_data_entrada}), 32'd0);
    repeat (3) @(negedge clock);
    check("abort_no_write", 32'(mem[1]), 32'(4'b0101));
    check("abort_no_resp", 32'(resp_valid), 32'd0);
    clear = 1'b1;
    check_sweep();
    issue(1'b0, 2'd1, 4'b0000, 1'b1, 4'b0000);
    wait_resp();
    issue(1'b0, 2'd0, 4'b0000, 1'b1, 4'b0000);
    wait_resp();

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
